// File: rtl/alu_arb_pkg.sv
// Shared constants and FSM state type for the two-requester ALU arbiter.
package alu_arb_pkg;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [6:0] FUNC7_SUB  = 7'b0100000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: add/sub, OR, AND; unknown func3 yields zero.
module alu_core
   import alu_arb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [2:0]      func3,
   input  logic [6:0]      func7,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   always_comb begin
      result = '0;
      case (func3)
         F3_ADD_SUB: result = (func7 == FUNC7_SUB) ? (op1 - op2) : (op1 + op2);
         F3_OR:      result = op1 | op2;
         F3_AND:     result = op1 & op2;
         default:    result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one op per 3 cycles.
// Optional per-requester saturating grant counters built when ALU_ARB_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request; req_ready one-hot on the arbitration winner
// EXEC  | ALU evaluates latched operands; result registered at end of cycle
// RESP  | rsp_valid[owner] held until the owner's rsp_ready
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*XLEN-1:0]  req_reg1,
   input  logic [2*XLEN-1:0]  req_reg2,
   input  logic [2*XLEN-1:0]  req_imm,
   input  logic [5:0]         req_func3,
   input  logic [13:0]        req_func7,
   input  logic [1:0]         req_alusrc,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [XLEN-1:0]    rsp_result,
   output logic               rsp_zero,
   output logic [2*CNT_W-1:0] grant_cnt
);

   arb_state_e      state_q, state_d;
   logic            last_grant_q;
   logic            owner_q;
   logic [XLEN-1:0] op1_q, op2_q;
   logic [2:0]      f3_q;
   logic [6:0]      f7_q;
   logic [XLEN-1:0] result_q;
   logic            zero_q;

   logic            win;
   logic            accept;
   logic            rsp_done;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;

   // Tie goes to whichever requester was not granted last.
   assign win    = req_valid[1] & (~req_valid[0] | ~last_grant_q);
   assign accept = (state_q == ST_IDLE) && (req_valid != 2'b00);

   assign req_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_done  = (state_q == ST_RESP) && rsp_ready[owner_q];
   assign rsp_valid = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         op1_q        <= '0;
         op2_q        <= '0;
         f3_q         <= '0;
         f7_q         <= '0;
         result_q     <= '0;
         zero_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            last_grant_q <= win;
            owner_q      <= win;
            op1_q        <= win ? req_reg1[2*XLEN-1:XLEN] : req_reg1[XLEN-1:0];
            if (req_alusrc[win])
               op2_q <= win ? req_imm[2*XLEN-1:XLEN] : req_imm[XLEN-1:0];
            else
               op2_q <= win ? req_reg2[2*XLEN-1:XLEN] : req_reg2[XLEN-1:0];
            f3_q <= win ? req_func3[5:3]  : req_func3[2:0];
            f7_q <= win ? req_func7[13:7] : req_func7[6:0];
         end
         if (state_q == ST_EXEC) begin
            result_q <= alu_result;
            zero_q   <= alu_zero;
         end
      end
   end

   alu_core #(.XLEN(XLEN)) u_alu_core (
      .op1    (op1_q),
      .op2    (op2_q),
      .func3  (f3_q),
      .func7  (f7_q),
      .result (alu_result),
      .zero   (alu_zero)
   );

   assign rsp_result = result_q;
   assign rsp_zero   = zero_q;

`ifdef ALU_ARB_PERF_EN
   logic [CNT_W-1:0] cnt_q [2];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else if (accept && (cnt_q[win] != '1)) begin
         cnt_q[win] <= cnt_q[win] + CNT_W'(1);
      end
   end

   assign grant_cnt = {cnt_q[1], cnt_q[0]};
`else
   assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, scoreboard monitor, corner sequences.
module tb_alu_arbiter;

   localparam int XLEN    = 32;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic               clk;
   logic               rst_n;
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [2*XLEN-1:0]  req_reg1;
   logic [2*XLEN-1:0]  req_reg2;
   logic [2*XLEN-1:0]  req_imm;
   logic [5:0]         req_func3;
   logic [13:0]        req_func7;
   logic [1:0]         req_alusrc;
   logic [1:0]         rsp_valid;
   logic [1:0]         rsp_ready;
   logic [XLEN-1:0]    rsp_result;
   logic               rsp_zero;
   logic [2*CNT_W-1:0] grant_cnt;

   alu_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_reg1   (req_reg1),
      .req_reg2   (req_reg2),
      .req_imm    (req_imm),
      .req_func3  (req_func3),
      .req_func7  (req_func7),
      .req_alusrc (req_alusrc),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .grant_cnt  (grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          rq;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] imm;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        src;
      logic [31:0] exp_res;
      logic        exp_z;
   } vec_t;

   typedef struct {
      logic [1:0]  vbit;
      logic [31:0] res;
      logic        z;
   } exp_t;

   exp_t q[$];
   int   vectors;
   int   miscompares;
   int   cnt_model[2];
   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*CNT_W-1:0] exp_gc();
      logic [2*CNT_W-1:0] g;
      g = '0;
`ifdef ALU_ARB_PERF_EN
      for (int i = 0; i < 2; i++)
         g[i*CNT_W +: CNT_W] = (cnt_model[i] > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(cnt_model[i]);
`endif
      return g;
   endfunction

   // Every cycle with a response pending, compare against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && rsp_valid != 2'b00) begin
         if (q.size() == 0) begin
            check("rsp_spurious", {62'd0, rsp_valid}, 64'd0);
         end else begin
            check("rsp_route",  {62'd0, rsp_valid}, {62'd0, q[0].vbit});
            check("rsp_result", {32'd0, rsp_result}, {32'd0, q[0].res});
            check("rsp_zero",   {63'd0, rsp_zero}, {63'd0, q[0].z});
            if ((rsp_valid & rsp_ready) != 2'b00) void'(q.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst_n      = 1'b0;
      req_valid  = 2'b00;
      rsp_ready  = 2'b00;
      req_reg1   = '0;
      req_reg2   = '0;
      req_imm    = '0;
      req_func3  = '0;
      req_func7  = '0;
      req_alusrc = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cnt_model[0] = 0;
      cnt_model[1] = 0;
      q.delete();
   endtask

   task automatic drive_req(input vec_t v);
      req_reg1[v.rq*XLEN +: XLEN] = v.r1;
      req_reg2[v.rq*XLEN +: XLEN] = v.r2;
      req_imm[v.rq*XLEN +: XLEN]  = v.imm;
      req_func3[v.rq*3 +: 3]      = v.f3;
      req_func7[v.rq*7 +: 7]      = v.f7;
      req_alusrc[v.rq]            = v.src;
      req_valid[v.rq]             = 1'b1;
   endtask

   // Single-requester op; entered just after a rising edge with the DUT in IDLE.
   task automatic run_op(input vec_t v);
      logic [1:0] oh;
      exp_t       e;
      oh = (v.rq == 1) ? 2'b10 : 2'b01;
      drive_req(v);
      rsp_ready = 2'b11;
      #1 check("req_ready", {62'd0, req_ready}, {62'd0, oh});
      e.vbit = oh; e.res = v.exp_res; e.z = v.exp_z;
      q.push_back(e);
      cnt_model[v.rq]++;
      @(posedge clk); #1;
      req_valid = 2'b00;
      #1;
      check("exec_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      check("exec_req_ready", {62'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
      check("lat_rsp_valid", {62'd0, rsp_valid}, {62'd0, oh});
      @(posedge clk); #1;
      check("grant_cnt", {{(64-2*CNT_W){1'b0}}, grant_cnt}, {{(64-2*CNT_W){1'b0}}, exp_gc()});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      exp_t e;
      int   w;
      vectors     = 0;
      miscompares = 0;

      vecs[0] = '{0, 32'd5,          32'd3,  32'd0,   3'b000, 7'h00, 1'b0, 32'd8,          1'b0};
      vecs[1] = '{1, 32'd7,          32'd0,  32'd7,   3'b000, 7'h20, 1'b1, 32'd0,          1'b1};
      vecs[2] = '{0, 32'hF0,         32'h0F, 32'd0,   3'b110, 7'h00, 1'b0, 32'hFF,         1'b0};
      vecs[3] = '{1, 32'hF0,         32'd0,  32'h3C,  3'b111, 7'h00, 1'b1, 32'h30,         1'b0};
      vecs[4] = '{0, 32'd0,          32'd1,  32'd0,   3'b000, 7'h20, 1'b0, 32'hFFFF_FFFF,  1'b0};
      vecs[5] = '{1, 32'hFFFF_FFFF,  32'd1,  32'd0,   3'b000, 7'h00, 1'b0, 32'd0,          1'b1};
      vecs[6] = '{0, 32'd5,          32'd3,  32'd0,   3'b010, 7'h00, 1'b0, 32'd0,          1'b1};
      vecs[7] = '{0, 32'd5,          32'd3,  32'd0,   3'b000, 7'h01, 1'b0, 32'd8,          1'b0};
      vecs[8] = '{1, 32'd10,         32'd4,  32'd100, 3'b000, 7'h20, 1'b0, 32'd6,          1'b0};

      // Reset values
      do_reset();
      #1;
      check("rst_rsp_valid",  {62'd0, rsp_valid}, 64'd0);
      check("rst_rsp_result", {32'd0, rsp_result}, 64'd0);
      check("rst_rsp_zero",   {63'd0, rsp_zero}, 64'd0);
      check("rst_grant_cnt",  {{(64-2*CNT_W){1'b0}}, grant_cnt}, 64'd0);
      check("rst_ready_idle", {62'd0, req_ready}, 64'd0);
      req_valid = 2'b11;
      #1 check("rst_first_tie", {62'd0, req_ready}, 64'd1);
      req_valid = 2'b00;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run_op(vecs[i]);

      // Both requesters valid continuously: grants alternate starting with 0
      do_reset();
      req_reg1[31:0]  = 32'd1;  req_reg2[31:0]  = 32'd2; req_func3[2:0] = 3'b000;
      req_reg1[63:32] = 32'd10; req_reg2[63:32] = 32'd5; req_func3[5:3] = 3'b110;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         w = 0;
         while (req_ready == 2'b00 && w < 8) begin
            @(posedge clk); #1;
            w++;
         end
         check("alt_grant", {62'd0, req_ready}, (k % 2 == 1) ? 64'd2 : 64'd1);
         e.vbit = (k % 2 == 1) ? 2'b10 : 2'b01;
         e.res  = (k % 2 == 1) ? 32'd15 : 32'd3;
         e.z    = 1'b0;
         q.push_back(e);
         cnt_model[k % 2]++;
         @(posedge clk); #1;
      end
      req_valid = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      check("alt_drain", 64'(q.size()), 64'd0);
      check("alt_grant_cnt", {{(64-2*CNT_W){1'b0}}, grant_cnt}, {{(64-2*CNT_W){1'b0}}, exp_gc()});

      // Response backpressure with a non-owner rsp_ready in the middle
      v = '{0, 32'd100, 32'd1, 32'd0, 3'b000, 7'h20, 1'b0, 32'd99, 1'b0};
      drive_req(v);
      rsp_ready = 2'b00;
      #1 check("bp_ready", {62'd0, req_ready}, 64'd1);
      e.vbit = 2'b01; e.res = 32'd99; e.z = 1'b0;
      q.push_back(e);
      cnt_model[0]++;
      @(posedge clk); #1;
      req_valid = 2'b11;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", {62'd0, rsp_valid}, 64'd1);
         check("bp_req_ready", {62'd0, req_ready}, 64'd0);
         check("bp_result",    {32'd0, rsp_result}, 64'd99);
         rsp_ready = (i == 2) ? 2'b10 : 2'b00;
         @(posedge clk); #1;
      end
      check("bp_hold_valid", {62'd0, rsp_valid}, 64'd1);
      rsp_ready = 2'b01;
      @(posedge clk); #1;
      check("bp_release_valid", {62'd0, rsp_valid}, 64'd0);
      check("bp_release_ready", {62'd0, req_ready}, 64'd2);
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      #1 check("bp_drain", 64'(q.size()), 64'd0);

      // Reset while the op is in EXEC drops it silently
      v = '{1, 32'd7, 32'd1, 32'd0, 3'b000, 7'h00, 1'b0, 32'd8, 1'b0};
      drive_req(v);
      #1 check("rx_ready", {62'd0, req_ready}, 64'd2);
      @(posedge clk); #1;
      req_valid = 2'b00;
      rst_n     = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cnt_model[0] = 0;
      cnt_model[1] = 0;
      check("rx_rsp_valid",  {62'd0, rsp_valid}, 64'd0);
      check("rx_rsp_result", {32'd0, rsp_result}, 64'd0);
      req_valid = 2'b01;
      #1 check("rx_idle_ready", {62'd0, req_ready}, 64'd1);
      req_valid = 2'b00;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("rx_no_rsp", {62'd0, rsp_valid}, 64'd0);
      end
      check("rx_grant_cnt", {{(64-2*CNT_W){1'b0}}, grant_cnt}, 64'd0);

      // Five requester-0 grants; counters saturate when built
      v = '{0, 32'd5, 32'd3, 32'd0, 3'b010, 7'h00, 1'b0, 32'd0, 1'b1};
      for (int i = 0; i < 5; i++) run_op(v);
`ifdef ALU_ARB_PERF_EN
      check("sat_slice0", {{(64-CNT_W){1'b0}}, grant_cnt[CNT_W-1:0]}, 64'(CNT_MAX));
`else
      check("sat_slice0", {{(64-CNT_W){1'b0}}, grant_cnt[CNT_W-1:0]}, 64'd0);
`endif
      check("sat_slice1", {{(64-CNT_W){1'b0}}, grant_cnt[2*CNT_W-1:CNT_W]}, 64'd0);

      repeat (2) @(posedge clk);
      #1 check("final_drain", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
